pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It decides every cycle whether the IF/ID stages advance, hold, or are flushed, and whether a bubble is written into the ID/EX stage register. Inputs are register-dependency hazards, taken branches from EXE and multi-cycle SRAM accesses in MEM. It also keeps saturating stall and flush statistics and flags a stuck memory access.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
//   state_e          : controller states (RUN, MEM_WAIT, ERROR)
//   CNT_W_DEF        : default width of the statistics counters
//   MEM_TIMEOUT_DEF  : default number of MEM_WAIT cycles before ERROR
//   WAIT_W           : width of the memory wait counter (covers 1..65535)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned WAIT_W          = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: purely combinational register-dependency comparator.
// Ports:
//   src1, src2            : source registers of the ID instruction
//   use_src1, two_src     : which sources the ID instruction actually reads
//   exe_wb_en, exe_mem_read, exe_dest : EXE stage writer / load / destination
//   mem_wb_en, mem_dest   : MEM stage writer / destination
//   hazard                : ID instruction must wait one cycle
// With forwarding only a load in EXE can't be bypassed; without forwarding
// any pending write in EXE or MEM to a read source is a hazard. R0 is an
// ordinary register here, so no zero-register exemption.
module hazard_detect #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       use_src1,
  input  logic       two_src,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read,
  input  logic [3:0] exe_dest,
  input  logic       mem_wb_en,
  input  logic [3:0] mem_dest,
  output logic       hazard
);

  logic match_exe;
  logic match_mem;

  assign match_exe = exe_wb_en &&
                     ((use_src1 && (src1 == exe_dest)) ||
                      (two_src  && (src2 == exe_dest)));

  assign match_mem = mem_wb_en &&
                     ((use_src1 && (src1 == mem_dest)) ||
                      (two_src  && (src2 == mem_dest)));

  assign hazard = FORWARD_EN ? (exe_mem_read && match_exe)
                             : (match_exe || match_mem);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle advance/hold/flush decision for IF/ID and the
// ID/EX bubble, plus SRAM-wait tracking and saturating statistics.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   src1, src2, use_src1, two_src      : ID stage sources
//   exe_wb_en, exe_mem_read, exe_dest  : EXE stage writer info
//   mem_wb_en, mem_dest                : MEM stage writer info
//   branch_taken                       : taken branch resolved in EXE
//   mem_req, sram_ready                : MEM stage SRAM handshake
//   cnt_clr                            : synchronous statistics clear
//   freeze_if, flush_if, flush_id, stall_all : combinational pipeline controls
//   mem_err                            : sticky SRAM timeout flag
//   stall_cnt, flush_cnt               : saturating statistics
//
// state    | meaning
// RUN      | normal flow; hazards and branches resolved every cycle
// MEM_WAIT | SRAM access outstanding, whole pipeline held
// ERROR    | SRAM access timed out; held until reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          FORWARD_EN  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_all,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Last wait count before the timeout fires: entering MEM_WAIT loads 0, so
  // reaching MEM_TIMEOUT-1 without ready means MEM_TIMEOUT cycles spent.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hazard;
  logic              run_rules;
  logic              stall_inc;
  logic              flush_inc;

  hazard_detect #(
    .FORWARD_EN (FORWARD_EN)
  ) u_hazard_detect (
    .src1         (src1),
    .src2         (src2),
    .use_src1     (use_src1),
    .two_src      (two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    run_rules = 1'b0;
    freeze_if = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    stall_all = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !sram_ready) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = '0;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (sram_ready) begin
          // Access completes: the pipeline moves again this very cycle.
          run_rules = 1'b1;
          state_d   = RUN;
          wait_d    = '0;
        end else begin
          stall_all = 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = ERROR;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        stall_all = 1'b1;
        freeze_if = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    // Branch flush outranks a data hazard: the dependent instruction is
    // being discarded anyway.
    if (run_rules) begin
      if (branch_taken) begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        flush_inc = 1'b1;
      end else if (hazard) begin
        freeze_if = 1'b1;
        flush_id  = 1'b1;
        stall_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mem_err <= mem_err | (state_d == ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance with forwarding, one without,
// both MEM_TIMEOUT=8 and CNT_W=4, driven by the same inputs. Control-output
// expectations go into a queue when stimulus is applied and are popped at
// the following falling edge. Control vector order:
// {freeze_if, flush_if, flush_id, stall_all}.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       use_src1, two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, sram_ready, cnt_clr;

  logic       freeze_f, flush_if_f, flush_id_f, stall_f, mem_err_f;
  logic [3:0] stall_cnt_f, flush_cnt_f;
  logic       freeze_n, flush_if_n, flush_id_n, stall_n, mem_err_n;
  logic [3:0] stall_cnt_n, flush_cnt_n;

  wire [3:0] ctl_f = {freeze_f, flush_if_f, flush_id_f, stall_f};
  wire [3:0] ctl_n = {freeze_n, flush_if_n, flush_id_n, stall_n};

  typedef struct {
    string      tag;
    logic [3:0] ctl_f;
    logic [3:0] ctl_n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(8), .CNT_W(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .use_src1(use_src1),
    .two_src(two_src), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .cnt_clr(cnt_clr), .freeze_if(freeze_f), .flush_if(flush_if_f),
    .flush_id(flush_id_f), .stall_all(stall_f), .mem_err(mem_err_f),
    .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f));

  pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .use_src1(use_src1),
    .two_src(two_src), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .cnt_clr(cnt_clr), .freeze_if(freeze_n), .flush_if(flush_if_n),
    .flush_id(flush_id_n), .stall_all(stall_n), .mem_err(mem_err_n),
    .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n));

  task automatic idle();
    src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    use_src1 = 1'b0; two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
    sram_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load_use_r3();
    exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    src1 = 4'd3; use_src1 = 1'b1;
  endtask

  task automatic clr_cycle();
    idle();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    idle();
    #12;
    checks++; if (dut_f.state_q !== RUN) begin errors++; $display("FAIL reset_state got %0d want %0d", int'(dut_f.state_q), int'(RUN)); end
    checks++; if (mem_err_f !== 1'b0 || mem_err_n !== 1'b0) begin errors++; $display("FAIL reset_mem_err got %b/%b want 0/0", mem_err_f, mem_err_n); end
    checks++; if (stall_cnt_f !== 4'd0 || flush_cnt_f !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt_f, flush_cnt_f); end
    exp_q.push_back('{tag:"reset_ctl", ctl_f:4'b0000, ctl_n:4'b0000});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
    checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    exp_t e;
    clr_cycle();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin load_use_r3();
             exp_q.push_back('{tag:"lu_exe", ctl_f:4'b1010, ctl_n:4'b1010}); end
        1: begin src1 = 4'd3; use_src1 = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd3;
             exp_q.push_back('{tag:"lu_mem", ctl_f:4'b0000, ctl_n:4'b1010}); end
        default: exp_q.push_back('{tag:"lu_done", ctl_f:4'b0000, ctl_n:4'b0000});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt_f !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt_fwd got %0d want 1", stall_cnt_f); end
    checks++; if (stall_cnt_n !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt_nofwd got %0d want 2", stall_cnt_n); end
  endtask

  task automatic test_no_forward();
    exp_t e;
    clr_cycle();
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin src2 = 4'd5; two_src = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5;
             exp_q.push_back('{tag:"nf_exe", ctl_f:4'b0000, ctl_n:4'b1010}); end
        1: begin src2 = 4'd5; two_src = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd5;
             exp_q.push_back('{tag:"nf_mem", ctl_f:4'b0000, ctl_n:4'b1010}); end
        2: begin src1 = 4'd0; use_src1 = 1'b0; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
             exp_q.push_back('{tag:"nf_unused_src", ctl_f:4'b0000, ctl_n:4'b0000}); end
        3: begin src1 = 4'd0; use_src1 = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
             exp_q.push_back('{tag:"nf_r0_load", ctl_f:4'b1010, ctl_n:4'b1010}); end
        default: exp_q.push_back('{tag:"nf_done", ctl_f:4'b0000, ctl_n:4'b0000});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt_f !== 4'd1) begin errors++; $display("FAIL nf_stall_cnt_fwd got %0d want 1", stall_cnt_f); end
    checks++; if (stall_cnt_n !== 4'd3) begin errors++; $display("FAIL nf_stall_cnt_nofwd got %0d want 3", stall_cnt_n); end
  endtask

  task automatic test_back_to_back_branch();
    exp_t e;
    clr_cycle();
    for (int c = 0; c < 3; c++) begin
      idle();
      case (c)
        0: begin load_use_r3(); branch_taken = 1'b1;
             exp_q.push_back('{tag:"br_hazard", ctl_f:4'b0110, ctl_n:4'b0110}); end
        1: begin branch_taken = 1'b1;
             exp_q.push_back('{tag:"br_second", ctl_f:4'b0110, ctl_n:4'b0110}); end
        default: exp_q.push_back('{tag:"br_done", ctl_f:4'b0000, ctl_n:4'b0000});
      endcase
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
      if (c == 0) begin
        checks++; if (flush_cnt_f !== 4'd1 || stall_cnt_f !== 4'd0) begin errors++; $display("FAIL br_first_cnt got flush=%0d stall=%0d want 1/0", flush_cnt_f, stall_cnt_f); end
      end
    end
    checks++; if (flush_cnt_f !== 4'd2 || flush_cnt_n !== 4'd2) begin errors++; $display("FAIL br_flush_cnt got %0d/%0d want 2/2", flush_cnt_f, flush_cnt_n); end
    checks++; if (stall_cnt_n !== 4'd0) begin errors++; $display("FAIL br_stall_cnt got %0d want 0", stall_cnt_n); end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    clr_cycle();
    // 4 cycles without ready, then ready
    for (int c = 0; c < 5; c++) begin
      idle();
      mem_req = 1'b1;
      sram_ready = (c == 4);
      if (c < 4) exp_q.push_back('{tag:"mw_stall", ctl_f:4'b0001, ctl_n:4'b0001});
      else       exp_q.push_back('{tag:"mw_ready", ctl_f:4'b0000, ctl_n:4'b0000});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s[%0d] fwd got %b want %b", e.tag, c, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s[%0d] nofwd got %b want %b", e.tag, c, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
      if (c == 0) begin
        checks++; if (dut_f.state_q !== MEM_WAIT) begin errors++; $display("FAIL mw_enter_state got %0d want %0d", int'(dut_f.state_q), int'(MEM_WAIT)); end
      end
    end
    checks++; if (dut_f.state_q !== RUN) begin errors++; $display("FAIL mw_exit_state got %0d want %0d", int'(dut_f.state_q), int'(RUN)); end
    // hazard present during the wait: masked, then resolved on the ready cycle
    for (int c = 0; c < 3; c++) begin
      idle();
      load_use_r3();
      mem_req = 1'b1;
      sram_ready = (c == 2);
      if (c < 2) exp_q.push_back('{tag:"mwh_stall", ctl_f:4'b0001, ctl_n:4'b0001});
      else       exp_q.push_back('{tag:"mwh_ready", ctl_f:4'b1010, ctl_n:4'b1010});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s[%0d] fwd got %b want %b", e.tag, c, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s[%0d] nofwd got %b want %b", e.tag, c, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt_f !== 4'd1 || stall_cnt_n !== 4'd1) begin errors++; $display("FAIL mwh_stall_cnt got %0d/%0d want 1/1", stall_cnt_f, stall_cnt_n); end
  endtask

  task automatic test_timeout();
    exp_t   e;
    state_e st_exp;
    logic   err_exp;
    clr_cycle();
    // one RUN cycle that enters MEM_WAIT, then 8 MEM_WAIT cycles
    for (int i = 0; i <= 8; i++) begin
      idle();
      mem_req = 1'b1;
      exp_q.push_back('{tag:"to_wait", ctl_f:4'b0001, ctl_n:4'b0001});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s[%0d] fwd got %b want %b", e.tag, i, ctl_f, e.ctl_f); end
      checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s[%0d] nofwd got %b want %b", e.tag, i, ctl_n, e.ctl_n); end
      @(posedge clk); #1;
      st_exp  = (i == 8) ? ERROR : MEM_WAIT;
      err_exp = (i == 8);
      checks++; if (dut_n.state_q !== st_exp) begin errors++; $display("FAIL to_state[%0d] got %0d want %0d", i, int'(dut_n.state_q), int'(st_exp)); end
      checks++; if (mem_err_f !== err_exp || mem_err_n !== err_exp) begin errors++; $display("FAIL to_mem_err[%0d] got %b/%b want %b", i, mem_err_f, mem_err_n, err_exp); end
    end
    // ERROR ignores ready and branches
    idle();
    mem_req = 1'b1; sram_ready = 1'b1; branch_taken = 1'b1;
    exp_q.push_back('{tag:"err_hold", ctl_f:4'b1001, ctl_n:4'b1001});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
    checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
    @(posedge clk); #1;
    checks++; if (dut_f.state_q !== ERROR || mem_err_f !== 1'b1) begin errors++; $display("FAIL err_sticky got state=%0d err=%b want %0d/1", int'(dut_f.state_q), mem_err_f, int'(ERROR)); end
    checks++; if (flush_cnt_f !== 4'd0) begin errors++; $display("FAIL err_flush_cnt got %0d want 0", flush_cnt_f); end
    // asynchronous reset from ERROR
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut_f.state_q !== RUN || dut_n.state_q !== RUN) begin errors++; $display("FAIL rst_err_state got %0d/%0d want %0d", int'(dut_f.state_q), int'(dut_n.state_q), int'(RUN)); end
    checks++; if (mem_err_f !== 1'b0 || mem_err_n !== 1'b0) begin errors++; $display("FAIL rst_err_mem_err got %b/%b want 0/0", mem_err_f, mem_err_n); end
    checks++; if (ctl_f !== 4'b0000 || ctl_n !== 4'b0000) begin errors++; $display("FAIL rst_err_ctl got %b/%b want 0000", ctl_f, ctl_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    exp_t       e;
    logic [3:0] cnt_exp;
    clr_cycle();
    for (int k = 1; k <= 20; k++) begin
      idle();
      load_use_r3();
      exp_q.push_back('{tag:"sat_hazard", ctl_f:4'b1010, ctl_n:4'b1010});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s[%0d] fwd got %b want %b", e.tag, k, ctl_f, e.ctl_f); end
      @(posedge clk); #1;
      cnt_exp = (k > 15) ? 4'd15 : 4'(k);
      checks++; if (stall_cnt_f !== cnt_exp || stall_cnt_n !== cnt_exp) begin errors++; $display("FAIL sat_cnt[%0d] got %0d/%0d want %0d", k, stall_cnt_f, stall_cnt_n, cnt_exp); end
    end
    idle();
    load_use_r3();
    cnt_clr = 1'b1;
    exp_q.push_back('{tag:"sat_clr", ctl_f:4'b1010, ctl_n:4'b1010});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (ctl_f !== e.ctl_f) begin errors++; $display("FAIL %s fwd got %b want %b", e.tag, ctl_f, e.ctl_f); end
    checks++; if (ctl_n !== e.ctl_n) begin errors++; $display("FAIL %s nofwd got %b want %b", e.tag, ctl_n, e.ctl_n); end
    @(posedge clk); #1;
    checks++; if (stall_cnt_f !== 4'd0 || stall_cnt_n !== 4'd0) begin errors++; $display("FAIL sat_clr_cnt got %0d/%0d want 0/0", stall_cnt_f, stall_cnt_n); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_forward();
    test_back_to_back_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
